// File: rtl/mem_cmd_sequencer.sv
// Turns line-level load/read commands into the 32-bit instruction stream of the data-cache memory.
// Optional stall watchdog: define MEM_SEQ_TIMEOUT_EN.
module mem_cmd_sequencer #(
  parameter int FMA_COUNT         = 2,
  parameter int WORD_WIDTH        = 16,
  parameter int LINE_WIDTH        = FMA_COUNT * 3 * WORD_WIDTH,
  parameter int ADDR_LENGTH       = 9,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int IDLE_GAP          = 3,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         cmd_valid_in,
  output logic                         cmd_ready_out,
  input  logic [1:0]                   cmd_op_in,
  input  logic [ADDR_LENGTH-1:0]       cmd_addr_in,
  input  logic [LINE_WIDTH-1:0]        cmd_line_in,
  input  logic                         buf_valid_in,
  output logic                         buf_ack_out,
  input  logic                         mem_idle_in,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic                         instr_valid_out,
  output logic                         done_out,
  output logic                         err_out
);

  localparam int WORDS = FMA_COUNT * 3;
  localparam int IDX_W = $clog2(WORDS + 1);
  localparam int GAP_W = $clog2(IDLE_GAP + 1);

  localparam logic [1:0] OP_BUF = 2'b00;
  localparam logic [1:0] OP_IMM = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BUF, S_IMM, S_RD, S_WAIT, S_DONE
  } state_t;

  state_t                  r_state, w_next;
  logic [1:0]              r_rstSync;
  logic                    w_rstN;
  logic [1:0]              r_op;
  logic [ADDR_LENGTH-1:0]  r_addr;
  logic [LINE_WIDTH-1:0]   r_line;
  logic [IDX_W-1:0]        r_idx;
  logic [GAP_W-1:0]        r_gap;
  logic                    r_err;
  logic                    w_accept;
  logic                    w_gapDone;
  logic                    w_timeout;
  logic [IDX_W-1:0]        w_wordIdx;
  logic [LINE_WIDTH-1:0]   w_shifted;
  logic [WORD_WIDTH-1:0]   w_word;

  function automatic logic [INSTRUCTION_WIDTH-1:0] makeInstr(input logic [3:0] opc,
                                                              input logic [3:0] idx,
                                                              input logic [WORD_WIDTH-1:0] imm);
    return INSTRUCTION_WIDTH'({opc, idx, imm, 8'h00});
  endfunction

  // Reset asserts asynchronously so outputs drop at once, but releases on a clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_rstSync <= 2'b00;
    else           r_rstSync <= {r_rstSync[0], 1'b1};
  end
  assign w_rstN = r_rstSync[1];

  assign w_accept  = cmd_valid_in && (r_state == S_IDLE);
  assign w_gapDone = (r_gap == GAP_W'(IDLE_GAP));
  assign w_wordIdx = (r_idx >= IDX_W'(WORDS - 1)) ? IDX_W'(WORDS - 1) : r_idx;
  assign w_shifted = r_line << (w_wordIdx * WORD_WIDTH);
  assign w_word    = w_shifted[LINE_WIDTH-1 -: WORD_WIDTH];
  assign err_out   = r_err;

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_stall;
  logic            w_stuck;

  assign w_stuck   = ((r_state == S_BUF) && !buf_valid_in) ||
                     ((r_state == S_WAIT) && !(w_gapDone && mem_idle_in));
  assign w_timeout = w_stuck && (r_stall == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge w_rstN) begin
    if (!w_rstN)                   r_stall <= '0;
    else if (w_stuck && !w_timeout) r_stall <= r_stall + 1'b1;
    else                           r_stall <= '0;
  end
`else
  // Watchdog compiled out: a non-negative limit can never fire.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_in or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_line  <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= cmd_op_in;
        r_addr <= cmd_addr_in;
        r_line <= cmd_line_in;
        r_err  <= (cmd_op_in == OP_ILL);
      end
      if (w_timeout) r_err <= 1'b1;
      r_idx <= (r_state == S_IMM) ? r_idx + 1'b1 : '0;
      if (r_state != S_WAIT) r_gap <= '0;
      else if (!w_gapDone)   r_gap <= r_gap + 1'b1;
    end
  end

  // The commit beat of a LOAD_IMM re-sends the last word so memory commits the staged line.
  always_comb begin
    w_next          = r_state;
    cmd_ready_out   = 1'b0;
    instr_valid_out = 1'b0;
    instr_out       = '0;
    buf_ack_out     = 1'b0;
    done_out        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in && (cmd_op_in != OP_ILL)) w_next = S_ADDR;
      end
      S_ADDR: begin
        instr_valid_out = 1'b1;
        instr_out       = makeInstr(4'b1000, 4'h0, WORD_WIDTH'(r_addr));
        case (r_op)
          OP_BUF:  w_next = S_BUF;
          OP_IMM:  w_next = S_IMM;
          default: w_next = S_RD;
        endcase
      end
      S_BUF: begin
        if (buf_valid_in) begin
          instr_valid_out = 1'b1;
          instr_out       = makeInstr(4'b1010, 4'h0, '0);
          buf_ack_out     = 1'b1;
          w_next          = S_WAIT;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_IMM: begin
        instr_valid_out = 1'b1;
        instr_out       = makeInstr(4'b1001, 4'(w_wordIdx), w_word);
        if (r_idx == IDX_W'(WORDS)) w_next = S_WAIT;
      end
      S_RD: begin
        instr_valid_out = 1'b1;
        instr_out       = makeInstr(4'b1100, 4'h0, '0);
        w_next          = S_WAIT;
      end
      S_WAIT: begin
        if ((w_gapDone && mem_idle_in) || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        done_out = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
